wave_capture_mc: RTL

Multi-channel, triggered successor to the single-channel wave capture stage feeding the wave display.
- Accepts CHANNELS audio samples per new_sample strobe.
- Waits for a selectable trigger (free-run, rising or falling zero-crossing on a chosen channel).
- Serialises DEPTH samples per channel into the write half of a ping-pong sample RAM.
- Flips read_index when the display is idle, so the display always reads a complete, stable frame.

---
 rtl/wave_capture_mc.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/wave_capture_mc.sv
// Multi-channel triggered wave capture: waits for a trigger, serialises CHANNELS samples per
// strobe into the write half of a ping-pong RAM, and flips halves when the display is idle.
module wave_capture_mc #(
    parameter int  CHANNELS     = 2,
    parameter int  SAMPLE_WIDTH = 16,
    parameter int  STORE_WIDTH  = 8,
    parameter int  DEPTH_LOG2   = 8,
    localparam int CH_BITS      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int ADDR_WIDTH   = 1 + CH_BITS + DEPTH_LOG2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             new_sample,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_in,
    input  logic [1:0]                       trig_mode,
    input  logic [CH_BITS-1:0]               trig_channel,
    input  logic                             wave_display_idle,
    input  logic                             overrun_clr,
    output logic                             write_enable,
    output logic [ADDR_WIDTH-1:0]            write_address,
    output logic [STORE_WIDTH-1:0]           write_sample,
    output logic                             read_index,
    output logic                             armed,
    output logic                             frame_done,
    output logic                             overrun,
    output logic [1:0]                       state_dbg
);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    localparam logic [STORE_WIDTH-1:0] MSB_MASK = STORE_WIDTH'(1) << (STORE_WIDTH - 1);

    state_t                 state, state_nx;
    logic [STORE_WIDTH-1:0] conv [CHANNELS];
    logic [STORE_WIDTH-1:0] hold [CHANNELS];
    logic [CH_BITS-1:0]     ch_cnt;
    logic [CH_BITS-1:0]     ch_nx;
    logic [DEPTH_LOG2-1:0]  idx;
    logic                   prev_msb;
    logic                   cur_msb;
    logic                   accept;
    logic                   drop;
    logic                   trig_hit;
    logic                   start;
    logic                   flip;
    logic                   last_ch;
    logic                   last_idx;
    logic                   unused_low_bits;

    // Only the top STORE_WIDTH bits of each sample are stored; the rest are intentionally dropped.
    assign unused_low_bits = ^sample_in;

    // The serialiser is busy exactly while it is driving RAM writes.
    assign accept   = new_sample && !write_enable;
    assign drop     = new_sample && write_enable;
    assign last_ch  = (ch_cnt == CH_BITS'(CHANNELS - 1));
    assign last_idx = &idx;
    assign ch_nx    = ch_cnt + 1'b1;

    assign armed     = (state == ST_ARMED);
    assign state_dbg = state;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            conv[c] = sample_in[c*SAMPLE_WIDTH + SAMPLE_WIDTH - STORE_WIDTH +: STORE_WIDTH] ^ MSB_MASK;
        end
    end

    // Out-of-range trig_channel values fall back to channel 0.
    always_comb begin
        cur_msb = sample_in[SAMPLE_WIDTH-1];
        for (int c = 1; c < CHANNELS; c++) begin
            if (trig_channel == CH_BITS'(c)) begin
                cur_msb = sample_in[c*SAMPLE_WIDTH + SAMPLE_WIDTH - 1];
            end
        end
    end

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode)
            2'b00:   trig_hit = 1'b1;
            2'b01:   trig_hit = prev_msb && !cur_msb;
            2'b10:   trig_hit = !prev_msb && cur_msb;
            default: trig_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        flip     = 1'b0;
        case (state)
            ST_ARMED: begin
                if (accept && trig_hit) begin
                    start    = 1'b1;
                    state_nx = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                start = accept;
                if (write_enable && last_ch && last_idx) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wave_display_idle) begin
                    flip     = 1'b1;
                    state_nx = ST_ARMED;
                end
            end
            default: state_nx = ST_ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_ARMED;
            read_index    <= 1'b0;
            frame_done    <= 1'b0;
            overrun       <= 1'b0;
            prev_msb      <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
            ch_cnt        <= '0;
            idx           <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                hold[c] <= '0;
            end
        end else begin
            state      <= state_nx;
            frame_done <= flip;
            if (flip) begin
                read_index <= ~read_index;
            end
            if (accept) begin
                prev_msb <= cur_msb;
                hold     <= conv;
            end
            // A dropped strobe in the same cycle as a clear keeps overrun set.
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (start) begin
                write_enable  <= 1'b1;
                ch_cnt        <= '0;
                write_address <= {~read_index, {CH_BITS{1'b0}}, idx};
                write_sample  <= conv[0];
            end else if (write_enable) begin
                if (last_ch) begin
                    write_enable <= 1'b0;
                    idx          <= idx + 1'b1;
                end else begin
                    ch_cnt        <= ch_nx;
                    write_address <= {~read_index, ch_nx, idx};
                    write_sample  <= hold[ch_nx];
                end
            end
        end
    end

endmodule
